control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 266 ++++++++++++++++++++++++++
 tb/tb_control_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit: multi-cycle instruction sequencer for a simple register datapath.
// Walks FETCH/DECODE/EXEC/MEM/WB/WRITE, raising datapath strobes from state and
// the latched opcode, with a memory wait watchdog that forces FAULT.
// Optional feature macro: CU_MULDIV_EN enables multi-cycle mul/div; when it is
// undefined mul/div decode as illegal opcodes.
module control_unit #(
  parameter int MEM_TIMEOUT   = 15,
  parameter int MULDIV_CYCLES = 32
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iRun,
  input  logic [31:0] iInstr,
  input  logic        iCond,
  input  logic        iMemReady,
  output logic        ir_enable,
  output logic        ra_enable,
  output logic        rb_enable,
  output logic        rm_enable,
  output logic        rz0_enable,
  output logic        rz1_enable,
  output logic        ry_enable,
  output logic        rf_write,
  output logic        mb_select,
  output logic [1:0]  my_select,
  output logic [1:0]  mc_select,
  output logic [3:0]  alu_control,
  output logic        oMemRead,
  output logic        oMemWrite,
  output logic        oAddrSel,
  output logic        oPcInc,
  output logic        oPcLoad,
  output logic        oHalt,
  output logic        oFault,
  output logic [3:0]  oState
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_MEM    = 4'd3,
    S_WB     = 4'd4,
    S_WRITE  = 4'd5,
    S_HALT   = 4'd6,
    S_FAULT  = 4'd7
  } state_e;

  typedef enum logic [4:0] {
    OP_LD   = 5'b00000,
    OP_LDI  = 5'b00001,
    OP_ST   = 5'b00010,
    OP_ADD  = 5'b00011,
    OP_SUB  = 5'b00100,
    OP_AND  = 5'b00101,
    OP_OR   = 5'b00110,
    OP_ADDI = 5'b01100,
    OP_ANDI = 5'b01101,
    OP_ORI  = 5'b01110,
    OP_MUL  = 5'b01111,
    OP_DIV  = 5'b10000,
    OP_BR   = 5'b10010,
    OP_JAL  = 5'b10100,
    OP_NOP  = 5'b11010,
    OP_HALT = 5'b11011
  } op_e;

  localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

  state_e          state_q;
  op_e             op_q;
  logic            req_q;   // fetch request outstanding while in FETCH
  logic [WW-1:0]   wait_q;  // cycles of the current memory request without ready
  op_e             op_in;
  logic            unused_bits;

`ifdef CU_MULDIV_EN
  localparam int MDW = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;
  localparam logic [MDW-1:0] MD_LAST = MDW'(MULDIV_CYCLES - 1);
  logic [MDW-1:0]  md_q;
  logic            md_last;
  assign md_last = (md_q == MD_LAST);
`endif

  assign op_in       = op_e'(iInstr[31:27]);
  assign unused_bits = ^{iInstr[26:0], (MULDIV_CYCLES != 0)};

  // Sequencer: state, latched opcode, fetch request flag and wait/mul-div counters.
  // Every return to FETCH samples iRun there, so a ready fetch costs no extra cycle.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= S_FETCH;
      op_q    <= OP_NOP;
      req_q   <= 1'b0;
      wait_q  <= '0;
`ifdef CU_MULDIV_EN
      md_q    <= '0;
`endif
    end else begin
      case (state_q)
        S_FETCH: begin
          if (!req_q) begin
            req_q  <= iRun;
            wait_q <= '0;
          end else if (iMemReady) begin
            req_q   <= 1'b0;
            state_q <= S_DECODE;
          end else if (wait_q == WAIT_LAST) begin
            req_q   <= 1'b0;
            state_q <= S_FAULT;
          end else begin
            wait_q <= wait_q + WW'(1);
          end
        end
        S_DECODE: begin
          op_q <= op_in;
          case (op_in)
            OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_ADDI, OP_ANDI, OP_ORI, OP_BR, OP_JAL: state_q <= S_EXEC;
            OP_MUL, OP_DIV: begin
`ifdef CU_MULDIV_EN
              md_q    <= '0;
              state_q <= S_EXEC;
`else
              state_q <= S_FAULT;
`endif
            end
            OP_NOP: begin
              state_q <= S_FETCH;
              req_q   <= iRun;
              wait_q  <= '0;
            end
            OP_HALT: state_q <= S_HALT;
            default: state_q <= S_FAULT;
          endcase
        end
        S_EXEC: begin
          case (op_q)
            OP_BR: begin
              state_q <= S_FETCH;
              req_q   <= iRun;
              wait_q  <= '0;
            end
            OP_LD, OP_ST: begin
              state_q <= S_MEM;
              wait_q  <= '0;
            end
`ifdef CU_MULDIV_EN
            OP_MUL, OP_DIV: begin
              if (md_last) state_q <= S_WB;
              else         md_q    <= md_q + MDW'(1);
            end
`endif
            default: state_q <= S_WB;
          endcase
        end
        S_MEM: begin
          if (iMemReady) begin
            if (op_q == OP_ST) begin
              state_q <= S_FETCH;
              req_q   <= iRun;
              wait_q  <= '0;
            end else begin
              state_q <= S_WB;
            end
          end else if (wait_q == WAIT_LAST) begin
            state_q <= S_FAULT;
          end else begin
            wait_q <= wait_q + WW'(1);
          end
        end
        S_WB:    state_q <= S_WRITE;
        S_WRITE: begin
          state_q <= S_FETCH;
          req_q   <= iRun;
          wait_q  <= '0;
        end
        default: state_q <= state_q;
      endcase
    end
  end

  // Strobe decode: Moore on state/opcode; fetch completion and branch load are qualified.
  always_comb begin
    ir_enable   = 1'b0;
    ra_enable   = 1'b0;
    rb_enable   = 1'b0;
    rm_enable   = 1'b0;
    rz0_enable  = 1'b0;
    rz1_enable  = 1'b0;
    ry_enable   = 1'b0;
    rf_write    = 1'b0;
    mb_select   = 1'b0;
    my_select   = 2'd0;
    mc_select   = 2'd0;
    alu_control = 4'b0000;
    oMemRead    = 1'b0;
    oMemWrite   = 1'b0;
    oAddrSel    = 1'b0;
    oPcInc      = 1'b0;
    oPcLoad     = 1'b0;
    case (state_q)
      S_FETCH: begin
        oMemRead  = req_q;
        ir_enable = req_q & iMemReady;
        oPcInc    = req_q & iMemReady;
      end
      S_DECODE: begin
        ra_enable = 1'b1;
        rb_enable = 1'b1;
      end
      S_EXEC: begin
        rz0_enable = 1'b1;
        case (op_q)
          OP_SUB:          alu_control = 4'b0001;
          OP_OR,  OP_ORI:  alu_control = 4'b0010;
          OP_AND, OP_ANDI: alu_control = 4'b0011;
          OP_DIV:          alu_control = 4'b0100;
          OP_MUL:          alu_control = 4'b0101;
          default:         alu_control = 4'b0000;
        endcase
        case (op_q)
          OP_LD, OP_LDI, OP_ADDI, OP_ANDI, OP_ORI: mb_select = 1'b1;
          OP_ST: begin
            mb_select = 1'b1;
            rm_enable = 1'b1;
          end
          OP_BR:  oPcLoad = iCond;
          OP_JAL: oPcLoad = 1'b1;
`ifdef CU_MULDIV_EN
          OP_MUL, OP_DIV: begin
            rz0_enable = md_last;
            rz1_enable = md_last;
          end
`endif
          default: mb_select = 1'b0;
        endcase
      end
      S_MEM: begin
        oAddrSel  = 1'b1;
        oMemRead  = (op_q != OP_ST);
        oMemWrite = (op_q == OP_ST);
      end
      S_WB: begin
        ry_enable = 1'b1;
        case (op_q)
          OP_LD:   my_select = 2'd2;
          OP_JAL:  my_select = 2'd3;
          default: my_select = 2'd1;
        endcase
        mc_select = (op_q == OP_JAL) ? 2'd2 : 2'd0;
      end
      S_WRITE: begin
        rf_write  = 1'b1;
        mc_select = (op_q == OP_JAL) ? 2'd2 : 2'd0;
      end
      default: ir_enable = 1'b0;
    endcase
  end

  assign oHalt  = (state_q == S_HALT);
  assign oFault = (state_q == S_FAULT);
  assign oState = state_q;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed cycle-by-cycle checks of control_unit state, strobes
// and mux selects. Honours CU_MULDIV_EN for the mul/div expectations.
module tb_control_unit;

  logic        iClk, iRst, iRun, iCond, iMemReady;
  logic [31:0] iInstr;
  logic ir_enable, ra_enable, rb_enable, rm_enable, rz0_enable, rz1_enable;
  logic ry_enable, rf_write, mb_select, oMemRead, oMemWrite, oAddrSel;
  logic oPcInc, oPcLoad, oHalt, oFault;
  logic [1:0] my_select, mc_select;
  logic [3:0] alu_control, oState;

  int n_vec = 0;
  int n_err = 0;

  control_unit #(.MEM_TIMEOUT(15), .MULDIV_CYCLES(4)) dut (
    .iClk(iClk), .iRst(iRst), .iRun(iRun), .iInstr(iInstr), .iCond(iCond),
    .iMemReady(iMemReady), .ir_enable(ir_enable), .ra_enable(ra_enable),
    .rb_enable(rb_enable), .rm_enable(rm_enable), .rz0_enable(rz0_enable),
    .rz1_enable(rz1_enable), .ry_enable(ry_enable), .rf_write(rf_write),
    .mb_select(mb_select), .my_select(my_select), .mc_select(mc_select),
    .alu_control(alu_control), .oMemRead(oMemRead), .oMemWrite(oMemWrite),
    .oAddrSel(oAddrSel), .oPcInc(oPcInc), .oPcLoad(oPcLoad), .oHalt(oHalt),
    .oFault(oFault), .oState(oState)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  localparam logic [3:0] FE = 4'd0, DE = 4'd1, EX = 4'd2, ME = 4'd3,
                         WB = 4'd4, WR = 4'd5, HA = 4'd6, FA = 4'd7;

  localparam logic [14:0] B_HALT = 15'h4000, B_FLT = 15'h2000, B_IR  = 15'h1000,
                          B_RA   = 15'h0800, B_RB  = 15'h0400, B_RM  = 15'h0200,
                          B_RZ0  = 15'h0100, B_RZ1 = 15'h0080, B_RY  = 15'h0040,
                          B_RF   = 15'h0020, B_MRD = 15'h0010, B_MWR = 15'h0008,
                          B_ADR  = 15'h0004, B_INC = 15'h0002, B_LD  = 15'h0001;
  localparam logic [14:0] B_FET = B_MRD | B_IR | B_INC;
  localparam logic [14:0] B_DEC = B_RA | B_RB;

  localparam logic [4:0] O_LD = 5'b00000, O_LDI = 5'b00001, O_ST = 5'b00010,
                         O_ADD = 5'b00011, O_SUB = 5'b00100, O_ORI = 5'b01110,
                         O_MUL = 5'b01111, O_BR = 5'b10010, O_JAL = 5'b10100,
                         O_NOP = 5'b11010, O_HALT = 5'b11011, O_BAD = 5'b00111;

  logic [14:0] strb;
  logic [8:0]  sels;
  assign strb = {oHalt, oFault, ir_enable, ra_enable, rb_enable, rm_enable,
                 rz0_enable, rz1_enable, ry_enable, rf_write, oMemRead,
                 oMemWrite, oAddrSel, oPcInc, oPcLoad};
  assign sels = {alu_control, mb_select, my_select, mc_select};

  function automatic logic [8:0] sl(input logic [3:0] a, input logic mb,
                                    input logic [1:0] my, input logic [1:0] mc);
    return {a, mb, my, mc};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Check one cycle at the falling edge, then move to just after the next rising edge.
  task automatic step(input string tag, input logic [3:0] st,
                      input logic [14:0] sb, input logic [8:0] sel);
    @(negedge iClk);
    chk({tag, ".state"}, 32'(oState), 32'(st));
    chk({tag, ".strb"},  32'(strb),   32'(sb));
    chk({tag, ".sel"},   32'(sels),   32'(sel));
    @(posedge iClk);
    #1;
  endtask

  task automatic do_reset;
    iRst = 1'b1;
    @(negedge iClk);
    chk("rst.state", 32'(oState), 32'(FE));
    chk("rst.strb",  32'(strb),   32'd0);
    chk("rst.sel",   32'(sels),   32'd0);
    @(posedge iClk);
    #1;
    iRst = 1'b0;
  endtask

  task automatic set_op(input logic [4:0] op);
    iInstr = {op, 27'h2A5_5A5A};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    iRst = 1'b1; iRun = 1'b0; iCond = 1'b0; iMemReady = 1'b1;
    iInstr = '0;
    #2;
    chk("async_rst.state", 32'(oState), 32'(FE));
    chk("async_rst.strb",  32'(strb),   32'd0);
    @(posedge iClk); #1;
    do_reset();
    iRun = 1'b1;

    // add with zero-wait memory
    set_op(O_ADD);
    step("add.idle",  FE, 15'd0, 9'd0);
    step("add.fetch", FE, B_FET, 9'd0);
    step("add.dec",   DE, B_DEC, 9'd0);
    step("add.exec",  EX, B_RZ0, sl(4'b0000, 1'b0, 2'd0, 2'd0));
    step("add.wb",    WB, B_RY,  sl(4'b0000, 1'b0, 2'd1, 2'd0));
    step("add.write", WR, B_RF,  sl(4'b0000, 1'b0, 2'd0, 2'd0));

    // ld with three wait cycles in MEM
    set_op(O_LD);
    step("ld.fetch", FE, B_FET, 9'd0);
    step("ld.dec",   DE, B_DEC, 9'd0);
    step("ld.exec",  EX, B_RZ0, sl(4'b0000, 1'b1, 2'd0, 2'd0));
    iMemReady = 1'b0;
    for (int unsigned i = 0; i < 3; i++) step("ld.memwait", ME, B_MRD | B_ADR, 9'd0);
    iMemReady = 1'b1;
    step("ld.memdone", ME, B_MRD | B_ADR, 9'd0);
    step("ld.wb",      WB, B_RY, sl(4'b0000, 1'b0, 2'd2, 2'd0));
    step("ld.write",   WR, B_RF, 9'd0);

    // st: four cycles fetch to fetch
    set_op(O_ST);
    step("st.fetch", FE, B_FET, 9'd0);
    step("st.dec",   DE, B_DEC, 9'd0);
    step("st.exec",  EX, B_RZ0 | B_RM, sl(4'b0000, 1'b1, 2'd0, 2'd0));
    step("st.mem",   ME, B_MWR | B_ADR, 9'd0);

    // br not taken, then taken
    set_op(O_BR); iCond = 1'b0;
    step("br0.fetch", FE, B_FET, 9'd0);
    step("br0.dec",   DE, B_DEC, 9'd0);
    step("br0.exec",  EX, B_RZ0, 9'd0);
    iCond = 1'b1;
    step("br1.fetch", FE, B_FET, 9'd0);
    step("br1.dec",   DE, B_DEC, 9'd0);
    step("br1.exec",  EX, B_RZ0 | B_LD, 9'd0);
    iCond = 1'b0;

    // sub and ori select checks
    set_op(O_SUB);
    step("sub.fetch", FE, B_FET, 9'd0);
    step("sub.dec",   DE, B_DEC, 9'd0);
    step("sub.exec",  EX, B_RZ0, sl(4'b0001, 1'b0, 2'd0, 2'd0));
    step("sub.wb",    WB, B_RY,  sl(4'b0000, 1'b0, 2'd1, 2'd0));
    step("sub.write", WR, B_RF,  9'd0);
    set_op(O_ORI);
    step("ori.fetch", FE, B_FET, 9'd0);
    step("ori.dec",   DE, B_DEC, 9'd0);
    step("ori.exec",  EX, B_RZ0, sl(4'b0010, 1'b1, 2'd0, 2'd0));
    step("ori.wb",    WB, B_RY,  sl(4'b0000, 1'b0, 2'd1, 2'd0));
    step("ori.write", WR, B_RF,  9'd0);

    // jal with link write; iRun drops in WRITE and stalls the next fetch
    set_op(O_JAL);
    step("jal.fetch", FE, B_FET, 9'd0);
    step("jal.dec",   DE, B_DEC, 9'd0);
    step("jal.exec",  EX, B_RZ0 | B_LD, 9'd0);
    step("jal.wb",    WB, B_RY, sl(4'b0000, 1'b0, 2'd3, 2'd2));
    iRun = 1'b0;
    step("jal.write", WR, B_RF, sl(4'b0000, 1'b0, 2'd0, 2'd2));
    step("stall0", FE, 15'd0, 9'd0);
    step("stall1", FE, 15'd0, 9'd0);
    iRun = 1'b1;
    step("stall2", FE, 15'd0, 9'd0);

    // ldi, with iRun low mid-instruction (must not stall), then nop
    set_op(O_LDI);
    step("ldi.fetch", FE, B_FET, 9'd0);
    iRun = 1'b0;
    step("ldi.dec",   DE, B_DEC, 9'd0);
    step("ldi.exec",  EX, B_RZ0, sl(4'b0000, 1'b1, 2'd0, 2'd0));
    iRun = 1'b1;
    step("ldi.wb",    WB, B_RY,  sl(4'b0000, 1'b0, 2'd1, 2'd0));
    step("ldi.write", WR, B_RF,  9'd0);
    set_op(O_NOP);
    step("nop.fetch", FE, B_FET, 9'd0);
    step("nop.dec",   DE, B_DEC, 9'd0);

    // halt is terminal
    set_op(O_HALT);
    step("halt.fetch", FE, B_FET, 9'd0);
    step("halt.dec",   DE, B_DEC, 9'd0);
    for (int unsigned i = 0; i < 3; i++) step("halt.hold", HA, B_HALT, 9'd0);
    do_reset();

    // illegal opcode
    set_op(O_BAD);
    step("bad.idle",  FE, 15'd0, 9'd0);
    step("bad.fetch", FE, B_FET, 9'd0);
    step("bad.dec",   DE, B_DEC, 9'd0);
    step("bad.fault", FA, B_FLT, 9'd0);
    do_reset();

    // mul
    set_op(O_MUL);
    step("mul.idle",  FE, 15'd0, 9'd0);
    step("mul.fetch", FE, B_FET, 9'd0);
    step("mul.dec",   DE, B_DEC, 9'd0);
`ifdef CU_MULDIV_EN
    for (int unsigned i = 0; i < 3; i++) step("mul.busy", EX, 15'd0, sl(4'b0101, 1'b0, 2'd0, 2'd0));
    step("mul.last",  EX, B_RZ0 | B_RZ1, sl(4'b0101, 1'b0, 2'd0, 2'd0));
    step("mul.wb",    WB, B_RY, sl(4'b0000, 1'b0, 2'd1, 2'd0));
    step("mul.write", WR, B_RF, 9'd0);
`else
    step("mul.fault", FA, B_FLT, 9'd0);
`endif
    do_reset();

    // fetch never completes: FAULT after the 15th wait cycle
    iMemReady = 1'b0;
    step("to.idle", FE, 15'd0, 9'd0);
    for (int unsigned i = 0; i < 15; i++) step("to.wait", FE, B_MRD, 9'd0);
    for (int unsigned i = 0; i < 3; i++) step("to.fault", FA, B_FLT, 9'd0);
    do_reset();

    // reset asserted during a MEM wait
    iMemReady = 1'b1;
    set_op(O_LD);
    step("rm.idle",  FE, 15'd0, 9'd0);
    step("rm.fetch", FE, B_FET, 9'd0);
    step("rm.dec",   DE, B_DEC, 9'd0);
    step("rm.exec",  EX, B_RZ0, sl(4'b0000, 1'b1, 2'd0, 2'd0));
    iMemReady = 1'b0;
    step("rm.mem",   ME, B_MRD | B_ADR, 9'd0);
    #2;
    iRst = 1'b1;
    #1;
    chk("rm.async.state", 32'(oState), 32'(FE));
    chk("rm.async.strb",  32'(strb),   32'd0);
    @(posedge iClk); #1;
    iRst = 1'b0; iMemReady = 1'b1;
    step("rm.idle2",  FE, 15'd0, 9'd0);
    step("rm.fetch2", FE, B_FET, 9'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
